// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic pipeline register with valid/ready on both sides.
// Empty stages absorb from upstream even under output stall, so held words pack toward the
// output. Synchronous active-high reset and synchronous flush; count reports valid stages.
module dff_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               d,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               q,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q   [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_dat [DEPTH];

  // Stage i may load when out_ready is high or any stage from i to the output is empty.
  // Written as a flat reduction rather than a rippling chain on the same vector.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!vld_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  // Input acceptance: blocked while flushing or in reset.
  always_comb begin
    in_ready = rdy[0] && !flush && !rst;
  end

  // Source of each stage: the input port for stage 0, otherwise the previous stage.
  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid && in_ready;
    src_dat[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i] = vld_q[i-1];
      src_dat[i] = dat_q[i-1];
    end
  end

  // Stage registers: reset clears valids and loads RESET_VAL; flush clears valids only.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          vld_q[i] <= 1'b0;
        end else if (rdy[i]) begin
          vld_q[i] <= src_vld[i];
          // Data only moves with a valid word so empty stages keep their last value.
          if (src_vld[i]) dat_q[i] <= src_dat[i];
        end
      end
    end
  end

  // Output side and occupancy, all straight from flops.
  always_comb begin
    out_valid = vld_q[DEPTH-1];
    q         = dat_q[DEPTH-1];
    count     = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CntW'(vld_q[i]);
  end

  // Producer must hold a refused word steady until it is accepted (flush cycles drop it).
  a_hold_valid : assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=> in_valid);
  a_hold_data : assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=> $stable(d));

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: two instances (8-bit x 3 stages, 16-bit x 1 stage with RESET_VAL DEAD),
// each compared every cycle against a queue model that treats the pipe as a FIFO whose head
// becomes visible DEPTH cycles after it was accepted.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_d, a_q;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_d, b_q;
  logic [0:0]  b_count;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_a (
    .clk      (clk),
    .rst      (rst),
    .flush    (a_flush),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .d        (a_d),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .q        (a_q),
    .count    (a_count)
  );

  dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'hDEAD)) u_b (
    .clk      (clk),
    .rst      (rst),
    .flush    (b_flush),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .d        (b_d),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .q        (b_q),
    .count    (b_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: words held, and the cycle at which each may first appear on q.
  logic [7:0]  qa_d[$];
  int          qa_t[$];
  logic [15:0] qb_d[$];
  int          qb_t[$];
  int          cyc = 0;
  bit          armed = 0;
  bit          fresh_a = 0, fresh_b = 0;
  bit          a_acc, a_pop, b_acc, b_pop;

  task automatic tick();
    bit a_ir, a_ov, b_ir, b_ov;
    @(negedge clk);
    a_ir = !rst && !a_flush && (qa_d.size() < 3 || a_out_ready);
    a_ov = qa_d.size() > 0 && cyc >= qa_t[0];
    b_ir = !rst && !b_flush && (qb_d.size() < 1 || b_out_ready);
    b_ov = qb_d.size() > 0 && cyc >= qb_t[0];
    if (armed) begin
      check("a_in_ready", 16'(a_in_ready), 16'(a_ir));
      check("a_out_valid", 16'(a_out_valid), 16'(a_ov));
      check("a_count", 16'(a_count), 16'(qa_d.size()));
      if (a_ov) check("a_q", 16'(a_q), 16'(qa_d[0]));
      else if (fresh_a) check("a_q_reset", 16'(a_q), 16'h0000);
      check("b_in_ready", 16'(b_in_ready), 16'(b_ir));
      check("b_out_valid", 16'(b_out_valid), 16'(b_ov));
      check("b_count", 16'(b_count), 16'(qb_d.size()));
      if (b_ov) check("b_q", b_q, qb_d[0]);
      else if (fresh_b) check("b_q_reset", b_q, 16'hDEAD);
    end
    if (a_ov) fresh_a = 0;
    if (b_ov) fresh_b = 0;
    a_acc = a_in_valid && a_ir;
    a_pop = a_ov && a_out_ready;
    b_acc = b_in_valid && b_ir;
    b_pop = b_ov && b_out_ready;
    @(posedge clk);
    if (rst) begin
      qa_d.delete(); qa_t.delete(); qb_d.delete(); qb_t.delete();
      fresh_a = 1; fresh_b = 1; armed = 1;
    end else begin
      if (a_pop) begin void'(qa_d.pop_front()); void'(qa_t.pop_front()); end
      if (a_flush) begin qa_d.delete(); qa_t.delete(); end
      else if (a_acc) begin qa_d.push_back(a_d); qa_t.push_back(cyc + 3); end
      if (b_pop) begin void'(qb_d.pop_front()); void'(qb_t.pop_front()); end
      if (b_flush) begin qb_d.delete(); qb_t.delete(); end
      else if (b_acc) begin qb_d.push_back(b_d); qb_t.push_back(cyc + 1); end
    end
    cyc++;
    #1;
  endtask

  // Present one word to instance A and hold it until the model says it was taken.
  task automatic send_a(input logic [7:0] w);
    int n;
    a_in_valid = 1'b1;
    a_d        = w;
    n          = 0;
    do begin
      tick();
      n++;
    end while (!a_acc && n < 50);
    check("a_send_accepted", 16'(a_acc), 16'd1);
    a_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_d = 8'hFF; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b1; b_d = 16'hFFFF; b_out_ready = 1'b1;

    // Reset with the producer pushing; nothing may enter.
    repeat (2) tick();
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    tick();

    // Streaming at full rate.
    for (int i = 1; i <= 10; i++) send_a(8'(i));
    repeat (5) tick();

    // Backpressure: three fit, the fourth waits.
    a_out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_a(8'(i));
    a_in_valid = 1'b1; a_d = 8'h04;
    repeat (4) tick();
    a_out_ready = 1'b1;
    send_a(8'h04);
    send_a(8'h05);
    repeat (5) tick();

    // Bubble collapse under stall.
    a_out_ready = 1'b0;
    send_a(8'hA0);
    tick();
    send_a(8'hB0);
    repeat (3) tick();

    // Flush with three held and a word offered in the flush cycle.
    send_a(8'hC0);
    a_flush = 1'b1; a_in_valid = 1'b1; a_d = 8'h77;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    repeat (3) tick();
    a_out_ready = 1'b1;
    repeat (3) tick();

    // Single-stage instance at full throughput.
    b_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_d = 16'(16'h1000 + i);
      tick();
    end
    b_in_valid = 1'b0;
    tick();

    // Random traffic on both, with occasional flushes and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (!a_in_valid || a_acc || a_flush || rst) begin
        a_in_valid = ($urandom_range(0, 9) < 7);
        a_d        = 8'($urandom);
      end
      if (!b_in_valid || b_acc || b_flush || rst) begin
        b_in_valid = ($urandom_range(0, 9) < 7);
        b_d        = 16'($urandom);
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 39) == 0);
      b_flush     = ($urandom_range(0, 39) == 0);
      rst         = (i == 200);
      tick();
    end

    rst = 1'b0;
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit `dff` register: a WIDTH-bit, DEPTH-stage elastic pipeline register.
- Uses a valid/ready handshake on both sides, with per-stage valid tracking.
- Collapses bubbles, supports backpressure, synchronous flush and an occupancy count.
- Sits between any producer/consumer pair in the design that needs registered retiming without data loss under stall.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all held words
in_valid  input  1  producer presents d
in_ready  output  1  pipeline accepts d this cycle
d  input  WIDTH  input data
out_valid  output  1  q holds a valid word
out_ready  input  1  consumer takes q this cycle
q  output  WIDTH  output data
count  output  $clog2(DEPTH+1)  number of valid stages (0..DEPTH)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes on posedge clk.
- State: vld[i] and dat[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives the output.
- Ready chain (combinational from flops and out_ready):
  - rdy[DEPTH-1] = !vld[DEPTH-1] || out_ready
  - rdy[i] = !vld[i] || rdy[i+1]
  - in_ready = rdy[0] && !flush && !rst
- Stage update when rdy[i]:
  - vld[i] <= source valid (in_valid && in_ready for i=0, else vld[i-1]).
  - dat[i] <= source data only when the source is valid; otherwise dat[i] holds.
  - When !rdy[i], the stage holds.
- Outputs: out_valid = vld[DEPTH-1]; q = dat[DEPTH-1]; count = popcount(vld). All are derived from flops only, except in_ready.
- Transfers: in = in_valid && in_ready; out = out_valid && out_ready. Both may occur in the same cycle. Throughput is 1 word/cycle sustained.
- Latency: a word accepted in cycle c is on q with out_valid=1 in cycle c+DEPTH, provided no stall.
- Stall rule: while out_valid && !out_ready, q and out_valid stay stable until taken.
- Bubble collapse: an empty stage accepts from upstream even when downstream is stalled. With N valid words and the output stalled, the words pack into stages DEPTH-1 down to DEPTH-N.
- Full: count == DEPTH and !out_ready -> in_ready = 0. Full and out_ready=1 -> in_ready = 1; the pipe accepts and emits in the same cycle.
- Flush:
  - All vld <= 0 at the next edge; data registers hold.
  - in_ready = 0 during flush, so the input word is dropped.
  - Any output handshake in the flush cycle still counts as delivered.
- Reset:
  - All vld <= 0 and all dat <= RESET_VAL at the next edge.
  - in_ready = 0 while rst=1.
  - rst dominates flush and in_valid. Reset mid-stream discards all words.
- Post-reset values: out_valid=0, q=RESET_VAL, count=0, in_ready=1 (once rst is low).
- DEPTH=1: a single stage; in_ready = !vld[0] || out_ready.
- Producer/consumer obligations (checked by assertion):
  - d must be stable while in_valid && !in_ready.
  - in_valid must not drop before acceptance.
- No X on any output after the first reset edge.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1, d=8'hFF -> out_valid=0, count=0, q=8'h00, in_ready=0. After rst falls -> in_ready=1, count=0.
2. Streaming (DEPTH=3), out_ready=1: push 8'h01..8'h0A on consecutive cycles -> q=8'h01 with out_valid first in cycle 3 after the first input cycle; 8'h01..8'h0A follow one per cycle, in order; count holds 3 at steady state.
3. Backpressure: out_ready=0, offer 8'h01..8'h05 -> exactly 3 accepted; in_ready=0; count=3; q=8'h01 stable. Then out_ready=1 -> output sequence 8'h01..8'h05 with no gaps, none lost or duplicated.
4. Bubble collapse: out_ready=0; push 8'hA0, idle one cycle, push 8'hB0 -> 8'hA0 in stage 2, 8'hB0 in stage 1, count=2, in_ready=1.
5. Flush mid-stream: 3 words held, then flush=1 with in_valid=1, d=8'h77 -> next cycle count=0, out_valid=0; 8'h77 never appears on q.
6. DEPTH=1, WIDTH=16, RESET_VAL=16'hDEAD: after reset q=16'hDEAD. Random valid/ready stimulus -> output equals the input sequence; full throughput with out_ready=1.
